// File: rtl/lcd_text_sequencer.sv
// lcd_text_sequencer
//
// Upstream driver for a single-transaction character-LCD controller. After
// reset it sends the four HD44780 power-on commands. From then on it mirrors a
// 32-byte text buffer (2 lines x 16 characters) to the panel. Each byte is one
// start/done handshake with the controller. The host may write the buffer at
// any time, and any write causes a full repaint.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   wr_en      buffer write strobe, accepted every cycle
//   wr_addr    0-15 = line 1 cols 0-15, 16-31 = line 2 cols 0-15
//   wr_data    character code to store
//   init_done  set by the completion of the fourth init command, sticky
//   busy       low only while the sequencer sits idle
//   lcd_data   byte presented to the controller
//   lcd_rs     0 = command, 1 = character data
//   lcd_start  one-cycle request pulse to the controller
//   lcd_done   one-cycle completion pulse from the controller
//
// Build option:
//   LCD_SEQ_AUTOREFRESH_EN  when defined, the panel is repainted continuously
//                           after init. Buffer writes still mark the buffer
//                           dirty, but the dirty flag no longer gates refresh.

module lcd_text_sequencer #(
    parameter logic [7:0] FILL_CHAR  = 8'h20,  // reset content of every cell
    parameter logic [7:0] FUNC_SET   = 8'h38,  // 8-bit bus, 2 lines, 5x8 font
    parameter logic [7:0] DISP_CTRL  = 8'h0C,  // display on, cursor off
    parameter logic [7:0] ENTRY_MODE = 8'h06   // increment, no shift
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_start,
    input  logic       lcd_done
);

    typedef enum logic [2:0] {
        INIT_ISSUE,
        INIT_WAIT,
        IDLE,
        REF_ISSUE,
        REF_WAIT
    } state_t;

    localparam logic [7:0] CMD_CLEAR = 8'h01;  // init command 2
    localparam logic [7:0] CMD_LINE1 = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] CMD_LINE2 = 8'hC0;  // DDRAM address 0x40

    localparam logic [5:0] LAST_INIT_STEP = 6'd3;
    localparam logic [5:0] LINE2_STEP     = 6'd17;
    localparam logic [5:0] LAST_REF_STEP  = 6'd33;

    state_t     state_q, state_d;
    logic [5:0] step_q, step_d;
    logic [7:0] text_q [32];
    logic [7:0] text_d [32];
    logic       dirty_q, dirty_d;
    logic       init_done_q, init_done_d;
    logic       busy_q, busy_d;
    logic [7:0] lcd_data_q, lcd_data_d;
    logic       lcd_rs_q, lcd_rs_d;
    logic       lcd_start_q, lcd_start_d;

    logic [7:0] init_byte;
    logic [7:0] ref_byte;
    logic       ref_rs;
    logic [4:0] ref_addr;

    // ------------------------------------------------------------------
    // Byte selection for the current step.
    // ------------------------------------------------------------------

    // Init command for steps 0-3. Only the low two step bits matter here.
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default value
        // first. That way no path can leave it unassigned and infer a latch.
        init_byte = FUNC_SET;
        case (step_q[1:0])
            2'd0:    init_byte = FUNC_SET;
            2'd1:    init_byte = DISP_CTRL;
            2'd2:    init_byte = CMD_CLEAR;
            default: init_byte = ENTRY_MODE;
        endcase
    end

    // Refresh layout:
    //   step 0      -> line 1 address command
    //   steps 1-16  -> text[step-1]
    //   step 17     -> line 2 address command
    //   steps 18-33 -> text[step-2]
    // Using the low five step bits makes the line-2 offset wrap naturally:
    // steps 32 and 33 yield 0-2 and 1-2, which are 30 and 31 modulo 32.
    always_comb begin
        ref_byte = CMD_LINE1;
        ref_rs   = 1'b0;
        ref_addr = 5'd0;
        if (step_q == 6'd0) begin
            ref_byte = CMD_LINE1;
        end else if (step_q < LINE2_STEP) begin
            ref_addr = step_q[4:0] - 5'd1;
            ref_byte = text_q[ref_addr];
            ref_rs   = 1'b1;
        end else if (step_q == LINE2_STEP) begin
            ref_byte = CMD_LINE2;
        end else begin
            ref_addr = step_q[4:0] - 5'd2;
            ref_byte = text_q[ref_addr];
            ref_rs   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Text buffer: the host writes it every cycle, in any state.
    // ------------------------------------------------------------------
    always_comb begin
        text_d = text_q;
        if (wr_en) begin
            text_d[wr_addr] = wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        dirty_d     = dirty_q;
        init_done_d = init_done_q;
        lcd_data_d  = lcd_data_q;   // held stable through the WAIT states
        lcd_rs_d    = lcd_rs_q;
        lcd_start_d = 1'b0;

        case (state_q)
            INIT_ISSUE: begin
                lcd_data_d  = init_byte;
                lcd_rs_d    = 1'b0;
                lcd_start_d = 1'b1;
                state_d     = INIT_WAIT;
            end

            INIT_WAIT: begin
                if (lcd_done) begin
                    if (step_q == LAST_INIT_STEP) begin
                        init_done_d = 1'b1;
                        step_d      = 6'd0;
                        state_d     = IDLE;
                    end else begin
                        step_d  = step_q + 6'd1;
                        state_d = INIT_ISSUE;
                    end
                end
            end

            IDLE: begin
                if (dirty_q) begin
                    dirty_d = 1'b0;
                    step_d  = 6'd0;
                    state_d = REF_ISSUE;
                end
            end

            REF_ISSUE: begin
                // A write landing on this same edge is not seen here. The old
                // byte goes out, and the dirty flag set below forces a repaint.
                lcd_data_d  = ref_byte;
                lcd_rs_d    = ref_rs;
                lcd_start_d = 1'b1;
                state_d     = REF_WAIT;
            end

            REF_WAIT: begin
                if (lcd_done) begin
                    if (step_q == LAST_REF_STEP) begin
                        step_d = 6'd0;
`ifdef LCD_SEQ_AUTOREFRESH_EN
                        state_d = REF_ISSUE;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        step_d  = step_q + 6'd1;
                        state_d = REF_ISSUE;
                    end
                end
            end

            default: begin
                state_d = INIT_ISSUE;
                step_d  = 6'd0;
            end
        endcase

        // A write on the same edge as the idle-exit clear must survive.
        // Otherwise the new character could be missed by the refresh that
        // is just starting.
        if (wr_en) begin
            dirty_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the text buffer is reset along with the control state.
            // Its reset content is what gets painted after init, so it has
            // to be defined. That is why this memory is built from flops.
            for (int i = 0; i < 32; i++) begin
                text_q[i] <= FILL_CHAR;
            end
            state_q     <= INIT_ISSUE;
            step_q      <= 6'd0;
            dirty_q     <= 1'b1;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            lcd_data_q  <= 8'h00;
            lcd_rs_q    <= 1'b0;
            lcd_start_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            // All flops then update together from the same pre-edge values.
            text_q      <= text_d;
            state_q     <= state_d;
            step_q      <= step_d;
            dirty_q     <= dirty_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            lcd_data_q  <= lcd_data_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_start_q <= lcd_start_d;
        end
    end

    assign init_done = init_done_q;
    assign busy      = busy_q;
    assign lcd_data  = lcd_data_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_start = lcd_start_q;

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Testbench for lcd_text_sequencer.
//
// A controller stub answers every lcd_start with lcd_done five cycles later.
// A transaction-level model predicts which byte each transaction must carry
// and the cycle on which each lcd_start must appear. It works from the panel
// layout, the shadow text and the dirty rules. A compare process checks
// lcd_start, lcd_data, lcd_rs, busy and init_done on every falling edge.
// Directed scenarios also pin specific transactions to hand-computed bytes.
`timescale 1ns/1ps

module tb_lcd_text_sequencer;

    localparam int NONE = -100;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       wr_en   = 1'b0;
    logic [4:0] wr_addr = 5'd0;
    logic [7:0] wr_data = 8'h00;
    logic       init_done, busy, lcd_rs, lcd_start;
    logic [7:0] lcd_data;
    logic       stub_done = 1'b0;
    logic       spur_done = 1'b0;
    logic       lcd_done;

    assign lcd_done = stub_done | spur_done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lcd_text_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .init_done (init_done),
        .busy      (busy),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_start (lcd_start),
        .lcd_done  (lcd_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Controller stub: done 5 cycles after start. If stretch_next is
    // set, the next done is held for two cycles, so its second cycle
    // lands on the sequencer's following issue cycle.
    // ---------------------------------------------------------------
    int stub_timer   = 0;
    bit stretch_next = 1'b0;
    bit hold_done    = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                stub_timer = 0;
                hold_done  = 1'b0;
                stub_done  = 1'b0;
            end else begin
                stub_done = hold_done;
                hold_done = 1'b0;
                if (stub_timer > 0) begin
                    stub_timer--;
                    if (stub_timer == 0) begin
                        stub_done = 1'b1;
                        if (stretch_next) begin
                            hold_done    = 1'b1;
                            stretch_next = 1'b0;
                        end
                    end
                end
                if (lcd_start) stub_timer = 5;
            end
        end
    end

    // ---------------------------------------------------------------
    // Behavioural model (transaction level).
    // ---------------------------------------------------------------
    logic [7:0] shadow [32];
    logic [8:0] log_q [$];       // {rs, data} of every observed lcd_start
    int   cyc, due, txn, last_wr_edge;
    bit   idle, in_init, outstanding, dirty_m, init_done_m, prev_reset;
    logic [7:0] exp_data;
    logic       exp_rs;
    bit   pend_wr, pend_done;
    logic [4:0] pend_addr;
    logic [7:0] pend_wdata;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
        due          = NONE;
        txn          = -1;
        last_wr_edge = NONE;
        idle         = 1'b0;
        in_init      = 1'b1;
        outstanding  = 1'b0;
        dirty_m      = 1'b1;
        init_done_m  = 1'b0;
        exp_data     = 8'h00;
        exp_rs       = 1'b0;
        pend_wr      = 1'b0;
        pend_done    = 1'b0;
        pend_addr    = 5'd0;
        pend_wdata   = 8'h00;
    endtask

    // What transaction t of the current sequence must carry.
    function automatic logic [8:0] expected_txn(input bit init_phase, input int t);
        logic [7:0] init_seq [4];
        init_seq = '{8'h38, 8'h0C, 8'h01, 8'h06};
        if (init_phase) return {1'b0, init_seq[t[1:0]]};
        if (t == 0)     return {1'b0, 8'h80};
        if (t <= 16)    return {1'b1, shadow[5'(t - 1)]};
        if (t == 17)    return {1'b0, 8'hC0};
        return {1'b1, shadow[5'(t - 2)]};
    endfunction

    // A sequence has just finished. A pending dirty flag restarts the
    // refresh: idle for one cycle, issue state one cycle, then the start.
    task automatic end_sequence();
        idle = 1'b1;
        due  = dirty_m ? cyc + 2 : NONE;
    endtask

    initial begin
        bit exp_busy;
        model_reset();
        prev_reset = 1'b1;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                model_reset();
                prev_reset = 1'b1;
            end else begin
                if (prev_reset) begin
                    due        = cyc + 1;   // first rising edge after release
                    prev_reset = 1'b0;
                end
                // completion captured on the edge just passed
                if (pend_done && outstanding) begin
                    outstanding = 1'b0;
                    if (in_init && txn == 3) begin
                        init_done_m = 1'b1;
                        end_sequence();
                    end else if (!in_init && txn == 33) begin
`ifdef LCD_SEQ_AUTOREFRESH_EN
                        txn = -1;
                        due = cyc + 1;
`else
                        end_sequence();
`endif
                    end else begin
                        due = cyc + 1;
                    end
                end
                // a start must appear exactly when due
                check("lcd_start", 32'(lcd_start), 32'(due == cyc));
                if (lcd_start === 1'b1) log_q.push_back({lcd_rs, lcd_data});
                if (due == cyc) begin
                    if (idle) begin
                        idle    = 1'b0;
                        in_init = 1'b0;
                        txn     = -1;
                        // only a write on the idle-exit edge survives the clear
                        dirty_m = (last_wr_edge == cyc - 1);
                    end
                    txn++;
                    {exp_rs, exp_data} = expected_txn(in_init, txn);
                    outstanding = 1'b1;
                    due = NONE;
                end
                check("lcd_data", 32'(lcd_data), 32'(exp_data));
                check("lcd_rs", 32'(lcd_rs), 32'(exp_rs));
                check("init_done", 32'(init_done), 32'(init_done_m));
                exp_busy = !((idle && due != cyc + 1) || (in_init && txn == -1));
                check("busy", 32'(busy), 32'(exp_busy));
                // buffer write captured on the edge just passed
                if (pend_wr) begin
                    shadow[pend_addr] = pend_wdata;
                    dirty_m = 1'b1;
                    last_wr_edge = cyc;
                    if (idle && due == NONE) due = cyc + 2;
                end
                pend_wr    = wr_en;
                pend_addr  = wr_addr;
                pend_wdata = wr_data;
                pend_done  = lcd_done;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus helpers.
    // ---------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_char(input logic [4:0] a, input logic [7:0] d);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int spent;
        spent = 0;
        while (log_q.size() < n && spent < budget) begin
            tick(1);
            spent++;
        end
        check(name, 32'(log_q.size() >= n), 32'd1);
    endtask

    function automatic logic [8:0] log_at(input int i);
        if (i < log_q.size()) return log_q[i];
        return 9'h1FF;
    endfunction

    initial begin
        int base;
        #1000000;
        $display("FAIL watchdog: simulation did not end, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int base2;
        #3;
        check("reset lcd_data", 32'(lcd_data), 32'h00);
        check("reset lcd_start", 32'(lcd_start), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset init_done", 32'(init_done), 32'd0);
        tick(2);
        reset = 1'b0;

        // Init sequence followed by the first full repaint of blank text
        wait_log(38, 500, "init+refresh count");
        check("init cmd0", 32'(log_at(0)), 32'h038);
        check("init cmd1", 32'(log_at(1)), 32'h00C);
        check("init cmd2", 32'(log_at(2)), 32'h001);
        check("init cmd3", 32'(log_at(3)), 32'h006);
        check("ref line1 cmd", 32'(log_at(4)), 32'h080);
        check("ref first char", 32'(log_at(5)), 32'h120);
        check("ref line2 cmd", 32'(log_at(21)), 32'h0C0);
        check("ref last char", 32'(log_at(37)), 32'h120);

`ifdef LCD_SEQ_AUTOREFRESH_EN
        // Continuous repaint: the next refresh starts without any write
        wait_log(39, 100, "auto second refresh");
        check("auto restart cmd", 32'(log_at(38)), 32'h080);
        check("auto busy", 32'(busy), 32'd1);
`else
        tick(10);
        check("idle busy", 32'(busy), 32'd0);
        check("idle init_done", 32'(init_done), 32'd1);
        check("no extra refresh", 32'(log_q.size()), 32'd38);

        // A single write while idle: line 2 col 1 lands on step 19
        base = log_q.size();
        write_char(5'd17, 8'h41);
        wait_log(base + 34, 400, "write17 refresh");
        check("step19 char", 32'(log_at(base + 19)), 32'h141);
        check("step18 char", 32'(log_at(base + 18)), 32'h120);
        check("step17 cmd", 32'(log_at(base + 17)), 32'h0C0);
        tick(12);
        check("write17 idle busy", 32'(busy), 32'd0);
        check("write17 single refresh", 32'(log_q.size()), 32'(base + 34));

        // Write an already-sent cell during step 5: exactly one repaint follows
        base = log_q.size();
        write_char(5'd31, 8'h43);
        wait_log(base + 6, 100, "reach step5");
        write_char(5'd2, 8'h42);
        wait_log(base + 68, 800, "second refresh");
        check("first pass addr2 old", 32'(log_at(base + 3)), 32'h120);
        check("first pass addr31", 32'(log_at(base + 33)), 32'h143);
        check("second pass start", 32'(log_at(base + 34)), 32'h080);
        check("second pass addr2 new", 32'(log_at(base + 37)), 32'h142);
        tick(20);
        check("no third refresh", 32'(log_q.size()), 32'(base + 68));

        // Write addr 4 on the very edge that issues step 5
        base = log_q.size();
        write_char(5'd8, 8'h47);
        wait_log(base + 5, 100, "reach step4");
        tick(5);
        write_char(5'd4, 8'h48);
        wait_log(base + 68, 800, "collision refresh");
        check("collision old byte", 32'(log_at(base + 5)), 32'h120);
        check("addr8 char", 32'(log_at(base + 9)), 32'h147);
        check("collision new byte", 32'(log_at(base + 39)), 32'h148);
        tick(20);
        check("collision one extra", 32'(log_q.size()), 32'(base + 68));

        // Spurious done while idle is ignored
        base = log_q.size();
        spur_done = 1'b1;
        tick(1);
        spur_done = 1'b0;
        tick(10);
        check("spurious idle no start", 32'(log_q.size()), 32'(base));
        check("spurious idle busy", 32'(busy), 32'd0);

        // Done held into the issue cycle is ignored as well
        write_char(5'd0, 8'h45);
        wait_log(base + 3, 100, "reach step2");
        stretch_next = 1'b1;
        wait_log(base + 34, 400, "stretched refresh");
        check("addr0 char", 32'(log_at(base + 1)), 32'h145);
        tick(20);
        check("stretched count", 32'(log_q.size()), 32'(base + 34));

        // Reset in the middle of step 10's wait
        base = log_q.size();
        write_char(5'd5, 8'h46);
        wait_log(base + 11, 150, "reach step10");
        tick(2);
        #1;
        reset = 1'b1;
        #1;
        check("async reset lcd_data", 32'(lcd_data), 32'h00);
        check("async reset lcd_rs", 32'(lcd_rs), 32'd0);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset init_done", 32'(init_done), 32'd0);
        tick(3);
        reset = 1'b0;
        base2 = log_q.size();
        wait_log(base2 + 38, 500, "re-init");
        check("re-init cmd0", 32'(log_at(base2)), 32'h038);
        check("re-init addr0 blank", 32'(log_at(base2 + 5)), 32'h120);
        check("re-init addr5 blank", 32'(log_at(base2 + 10)), 32'h120);
        tick(12);
        check("re-init idle busy", 32'(busy), 32'd0);
`endif

        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
